ex_alu_sequencer: RTL and testbench
===================================

Name: ex_alu_sequencer

Overview:
- EX-stage controller that owns the single 16-bit ALU and sequences every operation issued to it.
- Simple ops are forwarded to the ALU as one transaction, and the registered result is returned.
- MUL is executed as an iterative shift-add loop that reuses the ALU adder.
- Asserts stall toward the pipeline while busy; one outstanding request at a time, no buffering.

Parameters:
- WIDTH, 16, datapath width.
- ALU_LAT, 1, clock edges from stable ALU inputs to a valid ALU result; range 1..4.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  4  bit3=1 means MUL (4'b1xxx, low bits ignored); otherwise [2:0] is the ALU control code.
- req_a  in  WIDTH  operand 1 (multiplicand for MUL).
- req_b  in  WIDTH  operand 2 (multiplier for MUL).
- resp_valid  out  1  one-cycle result strobe.
- resp_resultado  out  WIDTH  result.
- resp_zero  out  1  result==0.
- stall  out  1  high whenever state != IDLE.
- alu_entrada1  out  WIDTH  to ALU.
- alu_entrada2  out  WIDTH  to ALU.
- alu_ctrl  out  3  to ALU.
- alu_resultado  in  WIDTH  from ALU.
- alu_zero  in  1  from ALU.

Behaviour:
- ALU control codes: AND=000, OR=001, ADD=010, SUB=110, SLT=111. Other 3-bit codes are forwarded unmodified.
- Reset (async, any state, including mid-operation):
  - state goes to IDLE;
  - all outputs are 0 except req_ready=1;
  - internal acc, mcand, mplier, count and wait counter are cleared;
  - an in-flight operation is dropped with no resp_valid.
- Accept: req_valid && req_ready at a rising edge. Operands and op are latched. Later changes on req_* are ignored until the next accept. Requests while busy are not accepted and not stored.
- States:
  - IDLE: req_ready=1.
    - On accept with a non-MUL op: EXEC.
    - On accept with MUL: acc=0, mcand=req_a, mplier=req_b, count=WIDTH, then MUL_CHECK.
  - EXEC:
    - Drives alu_entrada1/2 and alu_ctrl from the latched values.
    - Lasts ALU_LAT+1 cycles.
    - On its final edge, resp_resultado<=alu_resultado and resp_zero<=alu_zero; go to DONE.
  - MUL_CHECK (1 cycle):
    - If count==0, go to DONE.
    - Else if mplier[0]==1, drive ALU with ADD(acc, mcand) and go to MUL_ADD.
    - Else mcand<<=1, mplier>>=1, count-=1, and stay in MUL_CHECK.
  - MUL_ADD:
    - Holds the ALU inputs for ALU_LAT+1 cycles.
    - On its final edge: acc<=alu_resultado, mcand<<=1, mplier>>=1, count-=1; go to MUL_CHECK.
  - DONE (1 cycle):
    - resp_valid=1.
    - For MUL, resp_resultado=acc and resp_zero=(acc==0).
    - Then IDLE. req_ready rises the cycle after DONE, so the minimum gap between accepts is 1 idle cycle.
- MUL arithmetic: unsigned, result is the low WIDTH bits. Bits shifted out of mcand are lost (wrap-around); no overflow flag.
- Single-op latency:
  - resp_valid is high in the cycle after edge E0+ALU_LAT+1, where E0 is the accept edge.
  - For ALU_LAT=1, resp_valid is high 2 edges after accept.
- Outside EXEC/MUL_ADD, the alu_* outputs hold their last values. resp_resultado holds until the next DONE.

Optional Feature:
- Macro: EX_SEQ_EARLY_EXIT_EN.
- Defined: MUL_CHECK also goes to DONE when mplier==0, even if count>0.
- Undefined: MUL always iterates all WIDTH bits (count reaches 0).
- Results are identical either way; only latency differs.

Decomposition:
- Shared package ex_pkg holds:
  - ALU control localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT);
  - OP_MUL bit index;
  - the state encoding (IDLE, EXEC, MUL_CHECK, MUL_ADD, DONE).
- No sub-module is needed. The FSM, wait counter and multiply registers sit in one module. The ALU itself is instantiated by the parent EX stage, not by this block.

Test Plan:
- ALU_LAT=1. SUB: req_a=3, req_b=1, op=0110 -> resp_valid 2 edges after accept, resp_resultado=2, resp_zero=0, stall=1 during EXEC.
- SUB 5-5 -> resp_resultado=0, resp_zero=1. AND 0x00F0&0x0F0F -> resp_resultado=0x0000, resp_zero=1.
- MUL: req_a=3, req_b=5:
  - with EX_SEQ_EARLY_EXIT_EN, DONE is entered 8 edges after accept;
  - without it, 21 edges;
  - resp_resultado=15 and resp_zero=0 in both cases.
- MUL 0x0100*0x0100 -> resp_resultado=0x0000, resp_zero=1 (wrap). MUL 0xFFFF*1 -> 0xFFFF.
- Hold req_valid=1 with new operands during a MUL -> req_ready=0; the second request is accepted only after DONE and its result is independent of the first.
- Assert reset during MUL_ADD -> immediate IDLE; resp_valid never pulses; the next request (ADD 2+2) returns 4.

Source files
------------

// File: rtl/ex_alu_sequencer_pkg.sv
// Shared EX-stage constants: ALU control codes, MUL opcode bit, and the
// sequencer state encoding.
package ex_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam int OP_MUL = 3;

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] EXEC      = 3'd1;
   localparam logic [2:0] MUL_CHECK = 3'd2;
   localparam logic [2:0] MUL_ADD   = 3'd3;
   localparam logic [2:0] DONE      = 3'd4;

endpackage

// File: rtl/ex_alu_sequencer.sv
// EX-stage sequencer owning the shared ALU; simple ops in one pass, MUL as a
// shift-add loop on the ALU adder. Define EX_SEQ_EARLY_EXIT_EN to stop MUL once
// the multiplier runs out of set bits.
module ex_alu_sequencer
   import ex_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int ALU_LAT = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             resp_valid,
   output logic [WIDTH-1:0] resp_resultado,
   output logic             resp_zero,
   output logic             stall,
   output logic [WIDTH-1:0] alu_entrada1,
   output logic [WIDTH-1:0] alu_entrada2,
   output logic [2:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_resultado,
   input  logic             alu_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [2:0]       state;
   logic [2:0]       wcnt;
   logic [WIDTH-1:0] acc, mcand, mplier;
   logic [CW-1:0]    count;
   logic             mul_end;
   logic             lat_hit;

`ifdef EX_SEQ_EARLY_EXIT_EN
   assign mul_end = (count == '0) || (mplier == '0);
`else
   assign mul_end = (count == '0);
`endif

   assign lat_hit    = (wcnt == 3'(ALU_LAT));
   assign req_ready  = (state == IDLE);
   assign stall      = (state != IDLE);
   assign resp_valid = (state == DONE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         wcnt           <= '0;
         acc            <= '0;
         mcand          <= '0;
         mplier         <= '0;
         count          <= '0;
         resp_resultado <= '0;
         resp_zero      <= 1'b0;
         alu_entrada1   <= '0;
         alu_entrada2   <= '0;
         alu_ctrl       <= '0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               if (req_op[OP_MUL]) begin
                  acc    <= '0;
                  mcand  <= req_a;
                  mplier <= req_b;
                  count  <= CW'(WIDTH);
                  state  <= MUL_CHECK;
               end else begin
                  // ALU input registers double as the operand latch for simple ops
                  alu_entrada1 <= req_a;
                  alu_entrada2 <= req_b;
                  alu_ctrl     <= req_op[2:0];
                  wcnt         <= '0;
                  state        <= EXEC;
               end
            end
            EXEC: begin
               if (lat_hit) begin
                  resp_resultado <= alu_resultado;
                  resp_zero      <= alu_zero;
                  state          <= DONE;
               end else begin
                  wcnt <= wcnt + 3'd1;
               end
            end
            MUL_CHECK: begin
               if (mul_end) begin
                  resp_resultado <= acc;
                  resp_zero      <= (acc == '0);
                  state          <= DONE;
               end else if (mplier[0]) begin
                  alu_entrada1 <= acc;
                  alu_entrada2 <= mcand;
                  alu_ctrl     <= ALU_ADD;
                  wcnt         <= '0;
                  state        <= MUL_ADD;
               end else begin
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  count  <= count - CW'(1);
               end
            end
            MUL_ADD: begin
               if (lat_hit) begin
                  acc    <= alu_resultado;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  count  <= count - CW'(1);
                  state  <= MUL_CHECK;
               end else begin
                  wcnt <= wcnt + 3'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_alu_sequencer.sv
// Directed bench for ex_alu_sequencer with a one-cycle registered ALU model.
module tb_ex_alu_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_op = '0;
   logic [15:0] req_a = '0, req_b = '0;
   logic        resp_valid;
   logic [15:0] resp_resultado;
   logic        resp_zero;
   logic        stall;
   logic [15:0] alu_entrada1, alu_entrada2;
   logic [2:0]  alu_ctrl;
   logic [15:0] alu_resultado = '0;
   logic        alu_zero = 1'b0;

   int vectors = 0;
   int miscompares = 0;
   int edges;

`ifdef EX_SEQ_EARLY_EXIT_EN
   localparam int MUL35_LAT = 8;
`else
   localparam int MUL35_LAT = 21;
`endif

   always #5 clock = ~clock;

   ex_alu_sequencer #(.WIDTH(16), .ALU_LAT(1)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b),
      .resp_valid(resp_valid), .resp_resultado(resp_resultado), .resp_zero(resp_zero),
      .stall(stall),
      .alu_entrada1(alu_entrada1), .alu_entrada2(alu_entrada2), .alu_ctrl(alu_ctrl),
      .alu_resultado(alu_resultado), .alu_zero(alu_zero)
   );

   function automatic logic [15:0] alu_f(input logic [2:0] c, input logic [15:0] a, b);
      case (c)
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b010:  return a + b;
         3'b110:  return a - b;
         3'b111:  return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
         default: return 16'd0;
      endcase
   endfunction

   always @(posedge clock) begin
      alu_resultado <= alu_f(alu_ctrl, alu_entrada1, alu_entrada2);
      alu_zero      <= (alu_f(alu_ctrl, alu_entrada1, alu_entrada2) == 16'd0);
   end

   // Waits for idle, presents one request and releases req_valid after the accept edge.
   task automatic drive_req(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      int n = 0;
      @(negedge clock);
      while (!req_ready && n < 200) begin
         @(negedge clock);
         n++;
      end
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
      @(posedge clock); #1;
      req_valid = 1'b0;
   endtask

   // Edges from accept until resp_valid is seen; -1 on timeout.
   task automatic wait_resp(output int e);
      e = -1;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clock); #1;
         if (resp_valid) begin
            e = i;
            break;
         end
      end
   endtask

   task automatic test_reset;
      #1;
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", req_ready); end
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b want 0", stall); end
      vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", resp_valid); end
      vectors++; if (resp_resultado !== 16'h0) begin miscompares++; $display("FAIL reset_result got %h want 0000", resp_resultado); end
      vectors++; if ({alu_entrada1, alu_entrada2, alu_ctrl} !== 35'h0) begin miscompares++; $display("FAIL reset_alu got %h/%h/%b want 0", alu_entrada1, alu_entrada2, alu_ctrl); end
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_sub;
      drive_req(4'b0110, 16'd3, 16'd1);
      vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL sub_stall got %b want 1", stall); end
      vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL sub_ready got %b want 0", req_ready); end
      vectors++; if (alu_ctrl !== 3'b110) begin miscompares++; $display("FAIL sub_ctrl got %b want 110", alu_ctrl); end
      wait_resp(edges);
      vectors++; if (edges !== 2) begin miscompares++; $display("FAIL sub_latency got %0d want 2", edges); end
      vectors++; if (resp_resultado !== 16'd2) begin miscompares++; $display("FAIL sub_result got %h want 0002", resp_resultado); end
      vectors++; if (resp_zero !== 1'b0) begin miscompares++; $display("FAIL sub_zero got %b want 0", resp_zero); end
      @(posedge clock); #1;
      vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL sub_strobe got %b want 0", resp_valid); end
      vectors++; if (resp_resultado !== 16'd2) begin miscompares++; $display("FAIL sub_hold got %h want 0002", resp_resultado); end
   endtask

   task automatic test_simple_ops;
      drive_req(4'b0110, 16'd5, 16'd5); wait_resp(edges);
      vectors++; if (edges !== 2) begin miscompares++; $display("FAIL sub55_latency got %0d want 2", edges); end
      vectors++; if ({resp_zero, resp_resultado} !== {1'b1, 16'h0000}) begin miscompares++; $display("FAIL sub55 got %b/%h want 1/0000", resp_zero, resp_resultado); end
      drive_req(4'b0000, 16'h00F0, 16'h0F0F); wait_resp(edges);
      vectors++; if ({resp_zero, resp_resultado} !== {1'b1, 16'h0000}) begin miscompares++; $display("FAIL and got %b/%h want 1/0000", resp_zero, resp_resultado); end
      drive_req(4'b0001, 16'h00F0, 16'h0F0F); wait_resp(edges);
      vectors++; if ({resp_zero, resp_resultado} !== {1'b0, 16'h0FFF}) begin miscompares++; $display("FAIL or got %b/%h want 0/0fff", resp_zero, resp_resultado); end
      drive_req(4'b0010, 16'h1234, 16'h0001); wait_resp(edges);
      vectors++; if ({resp_zero, resp_resultado} !== {1'b0, 16'h1235}) begin miscompares++; $display("FAIL add got %b/%h want 0/1235", resp_zero, resp_resultado); end
      drive_req(4'b0111, 16'hFFFF, 16'h0001); wait_resp(edges);
      vectors++; if ({resp_zero, resp_resultado} !== {1'b0, 16'h0001}) begin miscompares++; $display("FAIL slt got %b/%h want 0/0001", resp_zero, resp_resultado); end
   endtask

   task automatic test_mul;
      drive_req(4'b1000, 16'd3, 16'd5); wait_resp(edges);
      vectors++; if (edges !== MUL35_LAT) begin miscompares++; $display("FAIL mul35_latency got %0d want %0d", edges, MUL35_LAT); end
      vectors++; if ({resp_zero, resp_resultado} !== {1'b0, 16'd15}) begin miscompares++; $display("FAIL mul35 got %b/%h want 0/000f", resp_zero, resp_resultado); end
      drive_req(4'b1111, 16'h0100, 16'h0100); wait_resp(edges);
      vectors++; if ({resp_zero, resp_resultado} !== {1'b1, 16'h0000}) begin miscompares++; $display("FAIL mul_wrap got %b/%h want 1/0000", resp_zero, resp_resultado); end
      drive_req(4'b1000, 16'hFFFF, 16'h0001); wait_resp(edges);
      vectors++; if ({resp_zero, resp_resultado} !== {1'b0, 16'hFFFF}) begin miscompares++; $display("FAIL mul_ffff got %b/%h want 0/ffff", resp_zero, resp_resultado); end
      drive_req(4'b1000, 16'd7, 16'd0); wait_resp(edges);
      vectors++; if ({resp_zero, resp_resultado} !== {1'b1, 16'h0000}) begin miscompares++; $display("FAIL mul_x0 got %b/%h want 1/0000", resp_zero, resp_resultado); end
   endtask

   task automatic test_back_to_back;
      drive_req(4'b1000, 16'd3, 16'd5);
      @(negedge clock);
      req_valid = 1'b1; req_op = 4'b0010; req_a = 16'd7; req_b = 16'd9;
      vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_busy_ready got %b want 0", req_ready); end
      wait_resp(edges);
      vectors++; if (resp_resultado !== 16'd15) begin miscompares++; $display("FAIL b2b_first got %h want 000f", resp_resultado); end
      @(posedge clock); #1;
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_idle_ready got %b want 1", req_ready); end
      @(posedge clock); #1;
      req_valid = 1'b0;
      vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_accept got %b want 0", req_ready); end
      wait_resp(edges);
      vectors++; if (edges !== 2) begin miscompares++; $display("FAIL b2b_latency got %0d want 2", edges); end
      vectors++; if (resp_resultado !== 16'd16) begin miscompares++; $display("FAIL b2b_second got %h want 0010", resp_resultado); end
   endtask

   task automatic test_reset_mid;
      logic seen = 1'b0;
      drive_req(4'b1000, 16'd3, 16'd5);
      @(posedge clock); #1;
      @(negedge clock);
      reset = 1'b1;
      #1;
      vectors++; if ({req_ready, stall, resp_valid} !== 3'b100) begin miscompares++; $display("FAIL rst_mid_ctrl got %b want 100", {req_ready, stall, resp_valid}); end
      vectors++; if ({alu_entrada1, alu_entrada2, alu_ctrl} !== 35'h0) begin miscompares++; $display("FAIL rst_mid_alu got %h/%h/%b want 0", alu_entrada1, alu_entrada2, alu_ctrl); end
      repeat (2) @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clock); #1;
         if (resp_valid) seen = 1'b1;
      end
      vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL rst_mid_pulse got %b want 0", seen); end
      drive_req(4'b0010, 16'd2, 16'd2); wait_resp(edges);
      vectors++; if ({edges, resp_resultado} !== {32'd2, 16'd4}) begin miscompares++; $display("FAIL rst_mid_add got %0d/%h want 2/0004", edges, resp_resultado); end
   endtask

   initial begin
      test_reset;
      test_sub;
      test_simple_ops;
      test_mul;
      test_back_to_back;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
